// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants and FSM state type for the seven-segment scan controller.
package seven_seg_pkg;
  localparam int NDIG = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [6:0] SEG_BLANK = 7'b0;
  typedef enum logic [2:0] {IDLE, ADDR, LATCH, SHOW, BLANK} state_t;
endpackage

// File: rtl/seven_seg_slot_timer.sv
// seven_seg_slot_timer: loadable down-counter with terminal-count flag; holds at zero instead of wrapping.
module seven_seg_slot_timer #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         CLRN,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge CLK or negedge CLRN)
    if (!CLRN) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == '0);
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: 4-digit multiplexed scan of a 16x7 segment register file, 4 pages of 4 digits.
// Optional macro SEVEN_SEG_SCROLL_EN: page advances every SCROLL_FRAMES frames instead of following PAGE.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int SHOW_CYC      = 1000,
  parameter int BLANK_CYC     = 8,
  parameter int SCROLL_FRAMES = 64
) (
  input  logic       CLK,
  input  logic       CLRN,
  input  logic       EN,
  input  logic [1:0] PAGE,
  output logic [3:0] RA,
  input  logic [6:0] DATA,
  output logic [6:0] SEG,
  output logic [3:0] AN,
  output logic       FRAME_DONE
);
  localparam int MAXC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam int DW = $clog2(NDIG);
  state_t r_state, w_nxt;
  logic [DW-1:0] r_digit, w_digit_n;
  logic [1:0] r_page, w_page_n, w_start_page, w_new_page, w_stop_page;
  logic [3:0] r_ra;
  logic [6:0] r_seg;
  logic [3:0] r_an;
  logic r_fd, w_fd_n, w_load, w_tc, w_frame_end;
  logic [CW-1:0] w_ld_val, w_cnt;
  seven_seg_slot_timer #(.W(CW)) u_timer (
    .CLK(CLK), .CLRN(CLRN), .i_load(w_load), .i_val(w_ld_val), .o_cnt(w_cnt), .o_tc(w_tc)
  );
  assign w_frame_end = EN && r_state == BLANK && w_tc && r_digit == DW'(NDIG - 1);
`ifdef SEVEN_SEG_SCROLL_EN
  localparam int FW = $clog2(SCROLL_FRAMES + 1);
  logic [FW-1:0] r_fcnt;
  logic w_wrap;
  assign w_wrap       = (r_fcnt == FW'(SCROLL_FRAMES - 1));
  assign w_start_page = 2'd0;
  assign w_new_page   = w_wrap ? r_page + 2'd1 : r_page;
  assign w_stop_page  = 2'd0;
  always_ff @(posedge CLK or negedge CLRN)
    if (!CLRN) r_fcnt <= '0;
    else if (!EN) r_fcnt <= '0;
    else if (w_frame_end) r_fcnt <= w_wrap ? '0 : r_fcnt + 1'b1;
`else
  assign w_start_page = PAGE;
  assign w_new_page   = PAGE;
  assign w_stop_page  = r_page;
`endif
  always_comb begin
    w_nxt     = r_state;
    w_digit_n = r_digit;
    w_page_n  = r_page;
    w_load    = 1'b0;
    w_ld_val  = '0;
    case (r_state)
      IDLE: if (EN) begin
        w_nxt     = ADDR;
        w_digit_n = '0;
        w_page_n  = w_start_page;
      end
      ADDR: w_nxt = LATCH;
      LATCH: begin
        w_nxt    = SHOW;
        w_load   = 1'b1;
        w_ld_val = CW'(SHOW_CYC - 1);
      end
      SHOW: if (w_tc) begin
        w_nxt    = BLANK;
        w_load   = 1'b1;
        w_ld_val = CW'(BLANK_CYC - 1);
      end
      BLANK: if (w_tc) begin
        w_nxt     = ADDR;
        w_digit_n = r_digit + 1'b1;
        w_page_n  = w_frame_end ? w_new_page : r_page;
      end
      default: w_nxt = IDLE;
    endcase
    if (!EN) begin
      w_nxt     = IDLE;
      w_digit_n = '0;
      w_page_n  = w_stop_page;
    end
  end
  // FRAME_DONE is registered, so it is raised on entry to digit 3's final BLANK cycle
  assign w_fd_n = w_nxt == BLANK && r_digit == DW'(NDIG - 1) &&
                  (w_load ? (BLANK_CYC == 1) : (w_cnt == CW'(1)));
  always_ff @(posedge CLK or negedge CLRN)
    if (!CLRN) begin
      r_state <= IDLE;
      r_digit <= '0;
      r_page  <= '0;
      r_ra    <= '0;
      r_seg   <= SEG_BLANK;
      r_an    <= AN_OFF;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_digit <= w_digit_n;
      r_page  <= w_page_n;
      if (w_nxt == ADDR) r_ra <= {w_page_n, w_digit_n};
      r_seg   <= (w_nxt == IDLE) ? SEG_BLANK : (r_state == LATCH) ? DATA : r_seg;
      r_an    <= (w_nxt == SHOW) ? ~(4'b0001 << w_digit_n) : AN_OFF;
      r_fd    <= w_fd_n;
    end
  assign RA         = r_ra;
  assign SEG        = r_seg;
  assign AN         = r_an;
  assign FRAME_DONE = r_fd;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed bench with a registered-read register file model, SHOW_CYC=4, BLANK_CYC=2.
module tb_seven_seg_scan_ctrl;
  logic CLK = 0, CLRN = 1, EN = 0;
  logic [1:0] PAGE = 0;
  logic [6:0] DATA = 0;
  logic [3:0] RA, AN;
  logic [6:0] SEG;
  logic FRAME_DONE;
  logic [6:0] mem [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int n_asrt = 0, n_fail = 0;
  seven_seg_scan_ctrl #(.SHOW_CYC(4), .BLANK_CYC(2), .SCROLL_FRAMES(2)) dut (
    .CLK(CLK), .CLRN(CLRN), .EN(EN), .PAGE(PAGE), .RA(RA), .DATA(DATA),
    .SEG(SEG), .AN(AN), .FRAME_DONE(FRAME_DONE)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) DATA <= mem[RA];
  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag, input logic [3:0] ra);
    chk({tag, " ra"}, {3'b0, RA}, {3'b0, ra});
    chk({tag, " seg"}, SEG, 7'h00);
    chk({tag, " an"}, {3'b0, AN}, 7'h0F);
    chk({tag, " fd"}, {6'b0, FRAME_DONE}, 7'h00);
  endtask
  // slot layout: c%8 = 0 ADDR, 1 LATCH, 2..5 SHOW, 6..7 BLANK
  task automatic run_frame(input int base, input logic [6:0] prev, input int ncyc,
                           input int chg_at, input logic [1:0] chg_page);
    int d, p;
    logic [6:0] es;
    logic [3:0] ean;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      d = c / 8;
      p = c % 8;
      es = (p >= 2) ? mem[base + d] : (d == 0) ? prev : mem[base + d - 1];
      ean = 4'b1111;
      if (p >= 2 && p <= 5) ean[d] = 1'b0;
      chk($sformatf("b%0d c%0d ra", base, c), {3'b0, RA}, 7'(base + d));
      chk($sformatf("b%0d c%0d seg", base, c), SEG, es);
      chk($sformatf("b%0d c%0d an", base, c), {3'b0, AN}, {3'b0, ean});
      chk($sformatf("b%0d c%0d fd", base, c), {6'b0, FRAME_DONE}, (d == 3 && p == 7) ? 7'h01 : 7'h00);
      if (c == chg_at) PAGE = chg_page;
    end
  endtask
  initial begin
    #1 CLRN = 0;
    #2 chk_idle("rst", 4'd0);
    repeat (2) @(negedge CLK);
    CLRN = 1;
    repeat (2) begin
      @(negedge CLK);
      chk_idle("idle_en0", 4'd0);
    end
`ifdef SEVEN_SEG_SCROLL_EN
    begin
      int bases [9] = '{0, 0, 4, 4, 8, 8, 12, 12, 0};
      logic [6:0] prev = 7'h00;
      PAGE = 2'd3;
      EN = 1;
      for (int f = 0; f < 9; f++) begin
        run_frame(bases[f], prev, 32, -1, 2'd3);
        prev = mem[bases[f] + 3];
      end
    end
`else
    PAGE = 2'd0;
    EN = 1;
    run_frame(0, 7'h00, 32, 10, 2'd2);
    run_frame(8, mem[3], 32, -1, 2'd2);
    run_frame(8, mem[11], 20, -1, 2'd2);
    EN = 0;
    @(negedge CLK);
    chk_idle("en_drop", 4'd10);
    @(negedge CLK);
    chk_idle("en_drop_hold", 4'd10);
    PAGE = 2'd0;
    EN = 1;
    run_frame(0, 7'h00, 12, -1, 2'd0);
    #2 begin
      CLRN = 0;
      EN = 0;
    end
    #1 chk_idle("rst_async", 4'd0);
    @(negedge CLK);
    CLRN = 1;
    repeat (3) begin
      @(negedge CLK);
      chk_idle("post_rst", 4'd0);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
